// File: rtl/binary_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : binary_mul_rr_sched
// Description : Round-robin scheduler that shares one free-running pipelined
//               unsigned multiplier between NUM_REQ requesters. At most one
//               operand pair is accepted per cycle. A tag pipeline aligned to
//               the multiplier latency carries the requester ID of every
//               in-flight operation, so each product is returned together
//               with the ID of the requester that issued it.
// Ports       : clk, rst_n       - clock, asynchronous active-low reset
//               issue_en         - 1 allows new grants, 0 lets work drain
//               req/a_in/b_in    - per-requester request and packed operands
//               gnt              - one-hot combinational grant
//               mul_a/mul_b/     - registered operands and enable driven to
//               mul_en, mul_p    - the multiplier, and its product input
//               res_valid/res_id/- one-cycle result strobe, requester ID and
//               res_p              full-width product
//               busy             - an accepted operation is still pending
// Revision    : 1.0 - initial release
// ============================================================================
module binary_mul_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int LATENCY = 5,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_en,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_en,
  input  logic [2*WIDTH-1:0]       mul_p,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [2*WIDTH-1:0]       res_p,
  output logic                     busy
);

  localparam int              c_cnt_w   = $clog2(LATENCY + 2) + 1;
  localparam logic [ID_W:0]   c_num_req = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0]    r_ptr;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_mul_en;
  logic [LATENCY:0]   r_tag_v;
  logic [ID_W-1:0]    r_tag_id [0:LATENCY];
  logic               r_res_valid;
  logic [ID_W-1:0]    r_res_id;
  logic [2*WIDTH-1:0] r_res_p;
  logic [c_cnt_w-1:0] r_cnt;

  logic               w_gnt_any;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_idx;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_retire;

  // Search order starts at the pointer and wraps; the sum is one bit wider
  // than an ID so the wrap can be done with a single conditional subtract.
  // Gating with rst_n keeps gnt low for the whole time reset is asserted.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    if (rst_n && issue_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_sum = {1'b0, r_ptr} + (ID_W + 1)'(k);
        if (w_sum >= c_num_req) begin
          w_sum = w_sum - c_num_req;
        end
        w_idx = w_sum[ID_W-1:0];
        if (!w_gnt_any && req[w_idx]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = w_idx;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (w_gnt_any) begin
      gnt[w_gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_sel_a = a_in[i*WIDTH +: WIDTH];
        w_sel_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // The tail of the tag pipeline lines up with the product on mul_p.
  assign w_retire = r_tag_v[LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_mul_en <= 1'b0;
    end else begin
      r_mul_en <= 1'b1;
      if (w_gnt_any) begin
        r_ptr   <= (w_gnt_idx == c_last_id) ? '0 : w_gnt_idx + ID_W'(1);
        r_mul_a <= w_sel_a;
        r_mul_b <= w_sel_b;
      end
    end
  end

  // Stage 0 is loaded at the accept edge; LATENCY+1 stages bring the tag to
  // the tail exactly when the multiplier presents the matching product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v <= '0;
      for (int k = 0; k <= LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v     <= {r_tag_v[LATENCY-1:0], w_gnt_any};
      r_tag_id[0] <= w_gnt_idx;
      for (int k = 1; k <= LATENCY; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  // ID and product only update on a real result so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_p     <= '0;
    end else begin
      r_res_valid <= w_retire;
      if (w_retire) begin
        r_res_id <= r_tag_id[LATENCY];
        r_res_p  <= mul_p;
      end
    end
  end

  // Decrement on the same edge that raises res_valid, so busy is already
  // low during the strobe of the last pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case ({w_gnt_any, w_retire})
        2'b10:   r_cnt <= r_cnt + c_cnt_w'(1);
        2'b01:   r_cnt <= r_cnt - c_cnt_w'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_en    = r_mul_en;
  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_p     = r_res_p;
  assign busy      = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_binary_mul_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_mul_rr_sched
// Description : Self-checking bench for binary_mul_rr_sched. Contains a
//               free-running multiplier model and a queue-based reference of
//               the scheduler's externally visible behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_mul_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int LATENCY = 5;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     issue_en = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ*WIDTH-1:0] a_in = '0;
  logic [NUM_REQ*WIDTH-1:0] b_in = '0;
  logic [NUM_REQ-1:0]       gnt;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_en;
  logic [2*WIDTH-1:0]       mul_p;
  logic                     res_valid;
  logic [ID_W-1:0]          res_id;
  logic [2*WIDTH-1:0]       res_p;
  logic                     busy;

  binary_mul_rr_sched #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en), .req(req),
    .a_in(a_in), .b_in(b_in), .gnt(gnt), .mul_a(mul_a), .mul_b(mul_b),
    .mul_en(mul_en), .mul_p(mul_p), .res_valid(res_valid), .res_id(res_id),
    .res_p(res_p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier: operands present before edge k give P after edge k+LATENCY-1.
  logic [2*WIDTH-1:0] mp [0:LATENCY-1];
  assign mul_p = mp[LATENCY-1];
  always @(posedge clk) begin
    mp[0] <= {{WIDTH{1'b0}}, mul_a} * {{WIDTH{1'b0}}, mul_b};
    for (int k = 1; k < LATENCY; k++) mp[k] <= mp[k-1];
  end

  // Reference model: results are queued with the edge number they are due.
  typedef struct { int id; int p; int due; } res_t;
  res_t m_q[$];
  int   m_ptr = 0, m_edge = 0, m_res_id = 0, m_res_p = 0;
  logic m_res_valid = 1'b0, m_busy = 1'b0;
  int   n_checks = 0, n_errors = 0;

  function automatic int exp_grant();
    if (!rst_n || !issue_en) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req[(m_ptr + k) % NUM_REQ]) return (m_ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] exp_gnt();
    logic [NUM_REQ-1:0] v;
    int g;
    v = '0;
    g = exp_grant();
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic int opnd(input logic [NUM_REQ*WIDTH-1:0] bus, input int g);
    logic [WIDTH-1:0] t;
    t = bus[g*WIDTH +: WIDTH];
    return int'(t);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_ptr = 0; m_res_valid = 1'b0; m_res_id = 0; m_res_p = 0; m_busy = 1'b0;
  endtask

  // Advance one clock and update the model; ends 1 time unit after the edge.
  task automatic cycle();
    int g, p;
    res_t r;
    g = exp_grant();
    p = (g >= 0) ? opnd(a_in, g) * opnd(b_in, g) : 0;
    @(posedge clk);
    if (rst_n) begin
      m_edge++;
      if (g >= 0) begin
        r.id = g; r.p = p; r.due = m_edge + LATENCY + 1;
        m_q.push_back(r);
        m_ptr = (g + 1) % NUM_REQ;
      end
      m_res_valid = 1'b0;
      if (m_q.size() != 0 && m_q[0].due == m_edge) begin
        m_res_valid = 1'b1; m_res_id = m_q[0].id; m_res_p = m_q[0].p;
        void'(m_q.pop_front());
      end
      m_busy = (m_q.size() != 0);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b1111; issue_en = 1'b1;
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (gnt !== 4'b0 || mul_en !== 1'b0 || mul_a !== 4'd0 || mul_b !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_ctl: gnt=%b mul_en=%b mul_a=%0d mul_b=%0d, want 0", gnt, mul_en, mul_a, mul_b);
    end
    n_checks++;
    if (res_valid !== 1'b0 || res_id !== 2'd0 || res_p !== 8'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_res: v=%b id=%0d p=%0d busy=%b, want 0", res_valid, res_id, res_p, busy);
    end
    cycle();
    cycle();
    rst_n = 1'b1; req = '0;
    #1;
    cycle();
    n_checks++;
    if (mul_en !== 1'b1) begin
      n_errors++;
      $display("FAIL mul_en_rise: got %b want 1", mul_en);
    end
  endtask

  task automatic test_single();
    int seen = 0, seen_at = -1, busy_cycles = 0;
    req = 4'b0001; issue_en = 1'b1;
    a_in = 16'h0003; b_in = 16'h0005;
    #1;
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL single_gnt: got %b want 0001", gnt);
    end
    cycle();
    req = '0;
    if (busy) busy_cycles++;
    for (int k = 1; k <= 10; k++) begin
      cycle();
      if (busy) busy_cycles++;
      if (res_valid) begin seen++; seen_at = k; end
      n_checks++;
      if (res_valid !== m_res_valid || res_id !== ID_W'(m_res_id) || res_p !== 8'(m_res_p) || busy !== m_busy) begin
        n_errors++;
        $display("FAIL single_stream k=%0d: got v=%b id=%0d p=%0d busy=%b want v=%b id=%0d p=%0d busy=%b",
                 k, res_valid, res_id, res_p, busy, m_res_valid, m_res_id, m_res_p, m_busy);
      end
    end
    n_checks++;
    if (seen != 1 || seen_at != 6 || res_id !== 2'd0 || res_p !== 8'd15 || busy_cycles != 6) begin
      n_errors++;
      $display("FAIL single_result: count=%0d at=%0d id=%0d p=%0d busy_cycles=%0d want 1,6,0,15,6",
               seen, seen_at, res_id, res_p, busy_cycles);
    end
  endtask

  task automatic test_all_four();
    int ids[$], ps[$], eds[$];
    logic [NUM_REQ-1:0] e;
    do_reset();
    a_in = {4'd4, 4'd3, 4'd2, 4'd1}; b_in = 16'hFFFF;
    req = 4'b1111; issue_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) req = '0;
      #1;
      e = '0;
      if (i < 8) e[i % 4] = 1'b1;
      n_checks++;
      if (gnt !== e) begin
        n_errors++;
        $display("FAIL all4_gnt i=%0d: got %b want %b", i, gnt, e);
      end
      cycle();
      if (res_valid) begin ids.push_back(int'(res_id)); ps.push_back(int'(res_p)); eds.push_back(m_edge); end
      n_checks++;
      if (res_valid !== m_res_valid || res_id !== ID_W'(m_res_id) || res_p !== 8'(m_res_p) || busy !== m_busy) begin
        n_errors++;
        $display("FAIL all4_stream i=%0d: got v=%b id=%0d p=%0d busy=%b want v=%b id=%0d p=%0d busy=%b",
                 i, res_valid, res_id, res_p, busy, m_res_valid, m_res_id, m_res_p, m_busy);
      end
    end
    n_checks++;
    if (ids.size() != 8) begin
      n_errors++;
      $display("FAIL all4_count: got %0d want 8", ids.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (ids[i] != i || ps[i] != 15 * (i + 1) || eds[i] != eds[0] + i) begin
          n_errors++;
          $display("FAIL all4_result %0d: got id=%0d p=%0d edge+%0d want id=%0d p=%0d edge+%0d",
                   i, ids[i], ps[i], eds[i] - eds[0], i, 15 * (i + 1), i);
        end
      end
    end
  endtask

  task automatic test_rr_from_ptr2();
    int ord[3] = '{3, 0, 1};
    logic [NUM_REQ-1:0] e;
    do_reset();
    issue_en = 1'b1; req = 4'b0010;
    #1;
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL rr_setup: got %b want 0010", gnt);
    end
    cycle();
    req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      #1;
      e = '0; e[ord[i]] = 1'b1;
      n_checks++;
      if (gnt !== e) begin
        n_errors++;
        $display("FAIL rr_order i=%0d: got %b want %b", i, gnt, e);
      end
      cycle();
      req[ord[i]] = 1'b0;
    end
    for (int i = 0; i < 8; i++) cycle();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_drain: busy=%b want 0", busy);
    end
  endtask

  task automatic test_issue_off();
    int seen = 0;
    do_reset();
    req = 4'b1111; issue_en = 1'b1;
    a_in = 16'h4321; b_in = 16'h2222;
    for (int i = 0; i < 3; i++) cycle();
    issue_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++;
      if (gnt !== 4'b0) begin
        n_errors++;
        $display("FAIL off_gnt i=%0d: got %b want 0000", i, gnt);
      end
      cycle();
      if (res_valid) begin
        seen++;
        n_checks++;
        if (busy !== (seen < 3)) begin
          n_errors++;
          $display("FAIL off_busy result %0d: busy=%b want %b", seen, busy, seen < 3);
        end
      end
      n_checks++;
      if (res_valid !== m_res_valid || res_id !== ID_W'(m_res_id) || res_p !== 8'(m_res_p) || busy !== m_busy) begin
        n_errors++;
        $display("FAIL off_stream i=%0d: got v=%b id=%0d p=%0d busy=%b want v=%b id=%0d p=%0d busy=%b",
                 i, res_valid, res_id, res_p, busy, m_res_valid, m_res_id, m_res_p, m_busy);
      end
    end
    n_checks++;
    if (seen != 3 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL off_drain: results=%0d busy=%b want 3,0", seen, busy);
    end
    issue_en = 1'b1;
    #1;
    n_checks++;
    if (gnt !== 4'b1000) begin
      n_errors++;
      $display("FAIL off_ptr_hold: got %b want 1000", gnt);
    end
    req = '0;
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req = 4'b1111; issue_en = 1'b1;
    a_in = 16'h9ABC; b_in = 16'h7777;
    for (int i = 0; i < 4; i++) cycle();
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (busy !== 1'b0 || mul_en !== 1'b0 || mul_a !== 4'd0 || mul_b !== 4'd0 ||
        res_valid !== 1'b0 || res_id !== 2'd0 || res_p !== 8'd0 || gnt !== 4'b0) begin
      n_errors++;
      $display("FAIL rst_flight_now: busy=%b en=%b a=%0d b=%0d v=%b id=%0d p=%0d gnt=%b want all 0",
               busy, mul_en, mul_a, mul_b, res_valid, res_id, res_p, gnt);
    end
    cycle();
    rst_n = 1'b1; req = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL rst_flight_stale i=%0d: v=%b busy=%b want 0,0", i, res_valid, busy);
      end
    end
    req = 4'b0110;
    #1;
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_errors++;
      $display("FAIL rst_flight_first: got %b want 0010", gnt);
    end
    req = '0;
  endtask

  task automatic test_exhaustive();
    int got[$];
    do_reset();
    req = 4'b0010; issue_en = 1'b1; a_in = '0; b_in = '0;
    for (int v = 0; v < 256 + 10; v++) begin
      if (v < 256) begin
        a_in[7:4] = 4'(v >> 4);
        b_in[7:4] = 4'(v & 15);
      end else begin
        req = '0;
      end
      #1;
      if (v < 256) begin
        n_checks++;
        if (gnt !== 4'b0010) begin
          n_errors++;
          $display("FAIL exh_gnt v=%0d: got %b want 0010", v, gnt);
        end
      end
      cycle();
      if (res_valid) got.push_back(int'(res_p));
      n_checks++;
      if (res_valid !== m_res_valid || res_id !== ID_W'(m_res_id) || res_p !== 8'(m_res_p) || busy !== m_busy) begin
        n_errors++;
        $display("FAIL exh_stream v=%0d: got v=%b id=%0d p=%0d busy=%b want v=%b id=%0d p=%0d busy=%b",
                 v, res_valid, res_id, res_p, busy, m_res_valid, m_res_id, m_res_p, m_busy);
      end
    end
    n_checks++;
    if (got.size() != 256) begin
      n_errors++;
      $display("FAIL exh_count: got %0d want 256", got.size());
    end else begin
      for (int v = 0; v < 256; v++) begin
        n_checks++;
        if (got[v] != (v >> 4) * (v & 15)) begin
          n_errors++;
          $display("FAIL exh_product %0d*%0d: got %0d want %0d", v >> 4, v & 15, got[v], (v >> 4) * (v & 15));
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400 + 10; i++) begin
      if (i < 400) begin
        req      = 4'($urandom);
        issue_en = ($urandom_range(0, 7) != 0);
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
      end else begin
        req = '0;
      end
      #1;
      n_checks++;
      if (gnt !== exp_gnt()) begin
        n_errors++;
        $display("FAIL rand_gnt i=%0d: got %b want %b", i, gnt, exp_gnt());
      end
      cycle();
      n_checks++;
      if (res_valid !== m_res_valid || res_id !== ID_W'(m_res_id) || res_p !== 8'(m_res_p) || busy !== m_busy) begin
        n_errors++;
        $display("FAIL rand_stream i=%0d: got v=%b id=%0d p=%0d busy=%b want v=%b id=%0d p=%0d busy=%b",
                 i, res_valid, res_id, res_p, busy, m_res_valid, m_res_id, m_res_p, m_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_rr_from_ptr2();
    test_issue_off();
    test_reset_inflight();
    test_exhaustive();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
